// File: rtl/nco_bank.sv
// nco_bank: a bank of independent numerically-controlled oscillators.
// Each channel has a phase accumulator, a selectable waveform (noise, square,
// triangle, saw), a right-shift volume attenuator and an enable. The attenuated
// channel samples are registered individually and also summed into one
// saturated mix sample.
module nco_bank #(
    parameter int CHANNELS = 4,
    parameter int PHASE_W  = 16,
    parameter int AMP_W    = 4,
    parameter int OUT_W    = 6,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int ADDR_W  = CH_W + 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [PHASE_W-1:0]          wr_data,
    output logic [CHANNELS*AMP_W-1:0]   ch_out,
    output logic [OUT_W-1:0]            out,
    output logic [CHANNELS-1:0]         wrap
);

    localparam int P     = PHASE_W - 1;
    // Wide enough to add CHANNELS full-scale samples without overflow.
    localparam int SUM_W = AMP_W + CH_W + 1;
    // Common width for the saturation compare, always wider than both sides.
    localparam int CMP_W = ((SUM_W > OUT_W) ? SUM_W : OUT_W) + 1;

    // Register address split: upper bits pick the channel, LSB picks FREQ/CTRL.
    logic [CH_W-1:0] wr_ch;
    logic            wr_sel;

    assign wr_ch  = wr_addr[ADDR_W-1:1];
    assign wr_sel = wr_addr[0];

    // Per-channel architectural state.
    logic [PHASE_W-1:0] phase_q [CHANNELS];
    logic [PHASE_W-1:0] freq_q  [CHANNELS];
    logic               en_q    [CHANNELS];
    logic [1:0]         wave_q  [CHANNELS];
    logic [3:0]         vol_q   [CHANNELS];
    logic [14:0]        lfsr_q  [CHANNELS];

    // Per-channel combinational results.
    logic               freq_wr   [CHANNELS];
    logic               ctrl_wr   [CHANNELS];
    logic               phase_rst [CHANNELS];
    logic               carry     [CHANNELS];
    logic [PHASE_W-1:0] phase_add [CHANNELS];
    logic [AMP_W-1:0]   sample    [CHANNELS];
    logic [AMP_W-1:0]   atten     [CHANNELS];
    logic [SUM_W-1:0]   sum;
    logic [OUT_W-1:0]   mix;

    // Write decode, accumulator add, waveform shaping, attenuation and mixing.
    always_comb begin
        // NOTE: every variable assigned here gets a value on every path (the sum
        // is seeded first, each array element is written once per loop pass),
        // so no latch can be inferred.
        sum = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            freq_wr[c]   = wr_en && (wr_ch == CH_W'(c)) && !wr_sel;
            ctrl_wr[c]   = wr_en && (wr_ch == CH_W'(c)) &&  wr_sel;
            phase_rst[c] = ctrl_wr[c] && wr_data[6];

            {carry[c], phase_add[c]} = {1'b0, phase_q[c]} + {1'b0, freq_q[c]};

            case (wave_q[c])
                2'd0:    sample[c] = lfsr_q[c][14 -: AMP_W];
                2'd1:    sample[c] = phase_q[c][P] ? '1 : '0;
                2'd2:    sample[c] = phase_q[c][P] ? phase_q[c][P-1 -: AMP_W]
                                                   : ~phase_q[c][P-1 -: AMP_W];
                default: sample[c] = phase_q[c][P -: AMP_W];
            endcase

            // A shift of AMP_W or more naturally yields zero.
            atten[c] = en_q[c] ? (sample[c] >> vol_q[c]) : '0;
            sum      = sum + SUM_W'(atten[c]);
        end

        mix = (CMP_W'(sum) > CMP_W'({OUT_W{1'b1}})) ? {OUT_W{1'b1}} : OUT_W'(sum);
    end

    // Channel state: register writes, phase accumulation, carry pulse and LFSR stepping.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: the per-channel arrays are ordinary flops, not RAM, so every
        // element is cleared here; each LFSR gets a distinct non-zero seed so
        // it can never lock up at all-zeros.
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                phase_q[c] <= '0;
                freq_q[c]  <= '0;
                en_q[c]    <= 1'b0;
                wave_q[c]  <= 2'd0;
                vol_q[c]   <= 4'd0;
                lfsr_q[c]  <= 15'(c + 1);
                wrap[c]    <= 1'b0;
            end
        end else begin
            // NOTE: non-blocking assignments so every channel's add sees the
            // freq/enable values from before this edge, not the ones being written.
            for (int c = 0; c < CHANNELS; c++) begin
                if (phase_rst[c]) begin
                    phase_q[c] <= '0;
                    wrap[c]    <= 1'b0;
                end else if (en_q[c]) begin
                    phase_q[c] <= phase_add[c];
                    wrap[c]    <= carry[c];
                    if (carry[c]) begin
                        lfsr_q[c] <= {lfsr_q[c][13:0], lfsr_q[c][14] ^ lfsr_q[c][13]};
                    end
                end else begin
                    wrap[c] <= 1'b0;
                end

                if (freq_wr[c]) begin
                    freq_q[c] <= wr_data;
                end
                if (ctrl_wr[c]) begin
                    en_q[c]   <= wr_data[7];
                    vol_q[c]  <= wr_data[5:2];
                    wave_q[c] <= wr_data[1:0];
                end
            end
        end
    end

    // Output samples: registered from the current phase/LFSR, one cycle behind the phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ch_out <= '0;
            out    <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                ch_out[c*AMP_W +: AMP_W] <= atten[c];
            end
            out <= mix;
        end
    end

endmodule

// File: tb/tb_nco_bank.sv
// Self-checking bench for nco_bank: a table of vectors for the basic saw
// channel, hand-written sequences for the multi-cycle corner cases, and a
// randomized register-write phase, all against a behavioural model.
module tb_nco_bank;

    localparam int CH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [15:0] ch_out;
    logic [5:0]  out;
    logic [3:0]  wrap;
    logic [15:0] ch_out4;
    logic [3:0]  out4;
    logic [3:0]  wrap4;

    nco_bank #(.CHANNELS(4), .PHASE_W(16), .AMP_W(4), .OUT_W(6)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .ch_out(ch_out), .out(out), .wrap(wrap)
    );

    // Same bank with a narrow mix output to exercise saturation.
    nco_bank #(.CHANNELS(4), .PHASE_W(16), .AMP_W(4), .OUT_W(4)) dut4 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .ch_out(ch_out4), .out(out4), .wrap(wrap4)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int m_phase [CH];
    int m_freq  [CH];
    int m_en    [CH];
    int m_wave  [CH];
    int m_vol   [CH];
    int m_lfsr  [CH];
    int m_ch    [CH];
    int m_wrap  [CH];
    int m_out;
    int m_out4;

    function automatic int lfsr_next(input int l);
        return ((l << 1) & 32'h7fff) | (((l >> 14) ^ (l >> 13)) & 1);
    endfunction

    function automatic int wave_sample(input int c);
        int hi;
        int t;
        hi = m_phase[c] / 32768;
        t  = (m_phase[c] / 2048) % 16;
        case (m_wave[c])
            0:       return m_lfsr[c] / 2048;
            1:       return (hi != 0) ? 15 : 0;
            2:       return (hi != 0) ? t : 15 - t;
            default: return m_phase[c] / 4096;
        endcase
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_phase[c] = 0; m_freq[c] = 0; m_en[c] = 0; m_wave[c] = 0;
            m_vol[c] = 0; m_lfsr[c] = c + 1; m_ch[c] = 0; m_wrap[c] = 0;
        end
        m_out  = 0;
        m_out4 = 0;
    endtask

    // One rising edge: outputs from pre-edge state, then accumulate, then writes.
    task automatic model_edge(input bit we, input int addr, input int data);
        int sum;
        int wch;
        int wreg;
        sum  = 0;
        wch  = addr >> 1;
        wreg = addr & 1;
        for (int c = 0; c < CH; c++) begin
            m_ch[c] = (m_en[c] != 0) ? (wave_sample(c) >> m_vol[c]) : 0;
            sum += m_ch[c];
        end
        m_out  = (sum > 63) ? 63 : sum;
        m_out4 = (sum > 15) ? 15 : sum;
        for (int c = 0; c < CH; c++) begin
            if (we && wreg == 1 && wch == c && ((data >> 6) & 1) == 1) begin
                m_phase[c] = 0;
                m_wrap[c]  = 0;
            end else if (m_en[c] != 0) begin
                int t;
                t = m_phase[c] + m_freq[c];
                m_wrap[c]  = (t >= 65536) ? 1 : 0;
                m_phase[c] = t % 65536;
                if (m_wrap[c] != 0) m_lfsr[c] = lfsr_next(m_lfsr[c]);
            end else begin
                m_wrap[c] = 0;
            end
        end
        if (we) begin
            if (wreg == 0) begin
                m_freq[wch] = data & 16'hffff;
            end else begin
                m_en[wch]   = (data >> 7) & 1;
                m_vol[wch]  = (data >> 2) & 15;
                m_wave[wch] = data & 3;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [15:0] e_ch;
        logic [3:0]  e_wrap;
        for (int c = 0; c < CH; c++) begin
            e_ch[c*4 +: 4] = 4'(m_ch[c]);
            e_wrap[c]      = (m_wrap[c] != 0);
        end
        check({tag, " ch_out"}, 32'(ch_out), 32'(e_ch));
        check({tag, " out"},    32'(out),    32'(m_out));
        check({tag, " out4"},   32'(out4),   32'(m_out4));
        check({tag, " wrap"},   32'(wrap),   32'(e_wrap));
    endtask

    // Called at a falling edge: drive, take one rising edge, compare at the next falling edge.
    task automatic step(input string tag, input bit we, input logic [2:0] addr, input logic [15:0] data);
        wr_en   = we;
        wr_addr = addr;
        wr_data = data;
        @(posedge clk);
        model_edge(we, int'(addr), int'(data));
        @(negedge clk);
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        check_outputs(tag);
    endtask

    task automatic idle(input string tag, input int n);
        repeat (n) step(tag, 1'b0, 3'd0, 16'h0);
    endtask

    // Asynchronous reset between edges; outputs must clear before any clock edge.
    task automatic async_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        check({tag, " ch_out"}, 32'(ch_out), 32'h0);
        check({tag, " out"},    32'(out),    32'h0);
        check({tag, " wrap"},   32'(wrap),   32'h0);
        check({tag, " out4"},   32'(out4),   32'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  addr;
        logic [15:0] data;
        logic [3:0]  exp_ch0;
        logic [5:0]  exp_out;
        logic        exp_wrap;
    } vec_t;

    vec_t tbl [40];

    initial begin
        int cnt_hi;
        int cnt_bad;

        // Saw on channel 0: FREQ, CTRL, then a 0..15 ramp with a carry pulse on 15.
        tbl[0] = '{1'b1, 3'd0, 16'h1000, 4'd0, 6'd0, 1'b0};
        tbl[1] = '{1'b1, 3'd1, 16'h0083, 4'd0, 6'd0, 1'b0};
        for (int n = 2; n < 40; n++) begin
            int k;
            k = (n - 2) % 16;
            tbl[n] = '{1'b0, 3'd0, 16'h0, 4'(k), 6'(k), (k == 15)};
        end

        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        model_reset();
        #2;
        check("reset ch_out", 32'(ch_out), 32'h0);
        check("reset out",    32'(out),    32'h0);
        check("reset wrap",   32'(wrap),   32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Table-driven saw channel.
        for (int n = 0; n < 40; n++) begin
            step("saw", tbl[n].we, tbl[n].addr, tbl[n].data);
            check($sformatf("tbl[%0d] ch0", n),  32'(ch_out[3:0]), 32'(tbl[n].exp_ch0));
            check($sformatf("tbl[%0d] out", n),  32'(out),         32'(tbl[n].exp_out));
            check($sformatf("tbl[%0d] wrap", n), 32'(wrap[0]),     32'(tbl[n].exp_wrap));
        end

        // Reset in the middle of a running channel; silence afterwards.
        async_reset("midrun reset");
        idle("after reset", 6);
        check("after reset silent", 32'(out), 32'h0);

        // Triangle on channel 1: down 15..0, then up 0..15.
        step("tri setup", 1'b1, 3'd2, 16'h0800);
        step("tri setup", 1'b1, 3'd3, 16'h0082);
        for (int i = 0; i < 40; i++) begin
            step("tri", 1'b0, 3'd0, 16'h0);
            check($sformatf("tri shape %0d", i), 32'(ch_out[7:4]),
                  32'((i % 32) < 16 ? 15 - (i % 32) : (i % 32) - 16));
        end

        // Square on channel 2 at four volume settings.
        step("sq setup", 1'b1, 3'd4, 16'h4000);
        step("sq setup", 1'b1, 3'd5, 16'h0081);
        for (int i = 0; i < 8; i++) begin
            step("sq vol0", 1'b0, 3'd0, 16'h0);
            check($sformatf("sq vol0 %0d", i), 32'(ch_out[11:8]), 32'((i % 4) < 2 ? 0 : 15));
        end
        step("sq vol1 wr", 1'b1, 3'd5, 16'h0085);
        cnt_hi = 0; cnt_bad = 0;
        for (int i = 0; i < 8; i++) begin
            step("sq vol1", 1'b0, 3'd0, 16'h0);
            if (ch_out[11:8] == 4'd7) cnt_hi++;
            else if (ch_out[11:8] != 4'd0) cnt_bad++;
        end
        check("sq vol1 highs", 32'(cnt_hi), 32'd4);
        check("sq vol1 other", 32'(cnt_bad), 32'd0);
        foreach (tbl[0].data[i]) begin end
        step("sq vol4 wr", 1'b1, 3'd5, 16'h0091);
        cnt_bad = 0;
        for (int i = 0; i < 6; i++) begin
            step("sq vol4", 1'b0, 3'd0, 16'h0);
            if (ch_out[11:8] != 4'd0) cnt_bad++;
        end
        check("sq vol4 silent", 32'(cnt_bad), 32'd0);
        step("sq vol15 wr", 1'b1, 3'd5, 16'h00bd);
        cnt_bad = 0;
        for (int i = 0; i < 6; i++) begin
            step("sq vol15", 1'b0, 3'd0, 16'h0);
            if (ch_out[11:8] != 4'd0) cnt_bad++;
        end
        check("sq vol15 silent", 32'(cnt_bad), 32'd0);

        // Four aligned saw channels: freeze at phase 0, pre-advance so that the
        // staggered start leaves every channel at the same phase, then run.
        for (int c = 0; c < CH; c++) step("mix freq0", 1'b1, 3'(2*c), 16'h0);
        for (int c = 0; c < CH; c++) step("mix ctrl", 1'b1, 3'(2*c + 1), 16'h00c3);
        for (int c = 0; c < CH; c++) begin
            step("mix pre", 1'b1, 3'(2*c), 16'(((13 + c) % 16) * 16'h1000));
            step("mix pre", 1'b1, 3'(2*c), 16'h0);
        end
        for (int c = 0; c < CH; c++) step("mix go", 1'b1, 3'(2*c), 16'h1000);
        idle("mix settle", 1);
        for (int i = 0; i < 20; i++) begin
            int s;
            s = (i + 1) % 16;
            step("mix", 1'b0, 3'd0, 16'h0);
            check($sformatf("mix ch_out %0d", i), 32'(ch_out), 32'({4'(s), 4'(s), 4'(s), 4'(s)}));
            check($sformatf("mix out %0d", i),    32'(out),    32'(4 * s));
            check($sformatf("mix out4 %0d", i),   32'(out4),   32'((4 * s > 15) ? 15 : 4 * s));
        end

        // Noise on channel 3 from a fresh seed, then a phase reset mid-run.
        async_reset("noise reset");
        step("noise setup", 1'b1, 3'd6, 16'h8000);
        step("noise setup", 1'b1, 3'd7, 16'h0080);
        idle("noise", 33);
        step("noise prst", 1'b1, 3'd7, 16'h00c0);
        check("prst wrap0", 32'(wrap[3]), 32'd0);
        for (int j = 1; j <= 4; j++) begin
            step("noise post", 1'b0, 3'd0, 16'h0);
            check($sformatf("prst wrap%0d", j), 32'(wrap[3]), 32'((j % 2 == 0) ? 1 : 0));
        end
        idle("noise tail", 10);

        // Randomized register traffic against the model.
        for (int i = 0; i < 400; i++) begin
            bit          we;
            logic [2:0]  a;
            logic [15:0] d;
            we = ($urandom_range(0, 2) == 0);
            a  = 3'($urandom_range(0, 7));
            d  = 16'($urandom);
            step("rand", we, a, d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
